// File: rtl/mem_write_arbiter_if.sv
// Request/acknowledge and memory write bus between the two requesters and the
// shared memory write port. The requester side drives master, the arbiter slave.
// Signals: req0/addr0/data0/ack0 (CPU), req1/addr1/data1/ack1 (I/O),
//          mem_write/mem_addr/mem_data (to memory), busy (arbiter status).
interface mem_write_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] data0;
  logic              ack0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] data1;
  logic              ack1;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              busy;

  modport master (
    output req0, addr0, data0, req1, addr1, data1,
    input  ack0, ack1, mem_write, mem_addr, mem_data, busy
  );

  modport slave (
    input  req0, addr0, data0, req1, addr1, data1,
    output ack0, ack1, mem_write, mem_addr, mem_data, busy
  );
endinterface

// File: rtl/mem_write_arbiter.sv
// Two-port arbiter/sequencer for the shared memory write port: grants one
// requester, holds mem_write for WAIT_CYCLES cycles, then pulses that port's ack.
// Latency: req sampled at edge E -> mem_write E..E+WAIT_CYCLES-1, ack at E+WAIT_CYCLES.
// Backpressure: requests are only sampled in IDLE; a requester holds req until ack.
// Ports: i_clock, i_reset (async, active-high), io_bus (mem_write_arbiter_if.slave).
// Build option: define MEMARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise
// port 0 always wins ties.
module mem_write_arbiter #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  mem_write_arbiter_if.slave   io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_grant;      // port owning the current access
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_busy;
  logic              w_pick1;      // 1 when port 1 wins this IDLE sample
  logic              w_any_req;

`ifdef MEMARB_ROUND_ROBIN_EN
  logic              r_last_grant; // most recent winner; reset to 1 so the first tie goes to port 0
`endif

  assign w_any_req = io_bus.req0 | io_bus.req1;

  always_comb begin
    w_pick1 = 1'b0;
    if (io_bus.req1 && !io_bus.req0) begin
      w_pick1 = 1'b1;
    end else if (io_bus.req1 && io_bus.req0) begin
`ifdef MEMARB_ROUND_ROBIN_EN
      w_pick1 = ~r_last_grant;
`else
      w_pick1 = 1'b0;
`endif
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_grant      <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_busy       <= 1'b0;
`ifdef MEMARB_ROUND_ROBIN_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_grant     <= w_pick1;
            r_mem_addr  <= w_pick1 ? io_bus.addr1 : io_bus.addr0;
            r_mem_data  <= w_pick1 ? io_bus.data1 : io_bus.data0;
            r_mem_write <= 1'b1;
            r_cnt       <= CNT_LOAD;
            r_busy      <= 1'b1;
            r_state     <= ST_WRITE;
`ifdef MEMARB_ROUND_ROBIN_EN
            r_last_grant <= w_pick1;
`endif
          end
        end

        ST_WRITE: begin
          // Address/data are held; only the counter moves until it expires.
          if (r_cnt == 4'd0) begin
            r_mem_write <= 1'b0;
            r_ack0      <= ~r_grant;
            r_ack1      <= r_grant;
            r_state     <= ST_ACK;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        ST_ACK: begin
          // Requests are deliberately ignored here so the requester can drop req
          // on the ack edge without being granted a second time.
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_ack0      <= 1'b0;
          r_ack1      <= 1'b0;
          r_busy      <= 1'b0;
          r_mem_write <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_bus.mem_write = r_mem_write;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_data  = r_mem_data;
  assign io_bus.ack0      = r_ack0;
  assign io_bus.ack1      = r_ack1;
  assign io_bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed bench for mem_write_arbiter: one instance with WAIT_CYCLES=2 for the
// main scenarios and one with WAIT_CYCLES=1 for the shortest access.
module tb_mem_write_arbiter;

  logic clk;
  logic reset;

  int n_tests = 0;
  int n_fail  = 0;

  mem_write_arbiter_if #(.DATA_W(16), .ADDR_W(8)) bus  ();
  mem_write_arbiter_if #(.DATA_W(16), .ADDR_W(8)) bus1 ();

  mem_write_arbiter #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .i_clock (clk),
    .i_reset (reset),
    .io_bus  (bus.slave)
  );

  mem_write_arbiter #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(1)) dut1 (
    .i_clock (clk),
    .i_reset (reset),
    .io_bus  (bus1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full access on the WAIT_CYCLES=2 instance: wait (bounded) for mem_write,
  // then check the two write cycles and the ack cycle. Returns in the ack cycle.
  task automatic do_access(input string tag, input int port,
                           input logic [7:0] a, input logic [15:0] d);
    int n;
    n = 0;
    while (bus.mem_write !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_start"}, 32'(n < 20), 32'd1);
    chk({tag, "_addr"},  32'(bus.mem_addr), 32'(a));
    chk({tag, "_data"},  32'(bus.mem_data), 32'(d));
    chk({tag, "_busy"},  32'(bus.busy), 32'd1);
    chk({tag, "_noack"}, 32'({bus.ack0, bus.ack1}), 32'd0);
    step();
    chk({tag, "_mw2"},   32'(bus.mem_write), 32'd1);
    chk({tag, "_addr2"}, 32'(bus.mem_addr), 32'(a));
    step();
    chk({tag, "_mwoff"}, 32'(bus.mem_write), 32'd0);
    chk({tag, "_ack0"},  32'(bus.ack0), 32'(port == 0));
    chk({tag, "_ack1"},  32'(bus.ack1), 32'(port == 1));
  endtask

  initial begin
    int gap;
    int exp_port;

    reset      = 1'b1;
    bus.req0   = 1'b0; bus.addr0 = '0; bus.data0 = '0;
    bus.req1   = 1'b0; bus.addr1 = '0; bus.data1 = '0;
    bus1.req0  = 1'b0; bus1.addr0 = '0; bus1.data0 = '0;
    bus1.req1  = 1'b0; bus1.addr1 = '0; bus1.data1 = '0;

    // Reset values
    #2;
    chk("rst_mw",   32'(bus.mem_write), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr),  32'd0);
    chk("rst_data", 32'(bus.mem_data),  32'd0);
    chk("rst_ack",  32'({bus.ack0, bus.ack1}), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst1_mw",  32'(bus1.mem_write), 32'd0);
    step();
    step();
    reset = 1'b0;

    // Single write, with addr0 changed during WRITE
    bus.req0 = 1'b1; bus.addr0 = 8'h12; bus.data0 = 16'hBEEF;
    step();
    chk("sw_mw",   32'(bus.mem_write), 32'd1);
    chk("sw_addr", 32'(bus.mem_addr),  32'h12);
    chk("sw_data", 32'(bus.mem_data),  32'hBEEF);
    chk("sw_busy", 32'(bus.busy), 32'd1);
    bus.addr0 = 8'h34; bus.data0 = 16'h0000;
    step();
    chk("sw_mw2",   32'(bus.mem_write), 32'd1);
    chk("sw_hold",  32'(bus.mem_addr),  32'h12);
    chk("sw_holdd", 32'(bus.mem_data),  32'hBEEF);
    chk("sw_ack0e", 32'(bus.ack0), 32'd0);
    step();
    chk("sw_mwoff", 32'(bus.mem_write), 32'd0);
    chk("sw_ack0",  32'(bus.ack0), 32'd1);
    chk("sw_ack1",  32'(bus.ack1), 32'd0);
    chk("sw_busy3", 32'(bus.busy), 32'd1);
    chk("sw_keep",  32'(bus.mem_addr), 32'h12);
    bus.req0 = 1'b0;
    step();
    chk("sw_ackclr", 32'(bus.ack0), 32'd0);
    chk("sw_idle",   32'(bus.busy), 32'd0);
    step();
    chk("sw_noreq",  32'(bus.busy), 32'd0);

    // Reset during the first WRITE cycle
    bus.req0 = 1'b1; bus.addr0 = 8'h40; bus.data0 = 16'h1234;
    step();
    chk("rw_mw", 32'(bus.mem_write), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rw_mw0",   32'(bus.mem_write), 32'd0);
    chk("rw_busy0", 32'(bus.busy), 32'd0);
    chk("rw_ack0",  32'({bus.ack0, bus.ack1}), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("rw_rel", 32'({bus.ack0, bus.ack1, bus.mem_write}), 32'd0);
    do_access("rw_re", 0, 8'h40, 16'h1234);
    bus.req0 = 1'b0;
    step();
    step();

    // Fresh reset so the first tie starts from the reset grant history
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;

    // Simultaneous requests held high for four accesses
    bus.addr0 = 8'h10; bus.data0 = 16'h1111;
    bus.addr1 = 8'h20; bus.data1 = 16'h2222;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef MEMARB_ROUND_ROBIN_EN
      exp_port = i % 2;
`else
      exp_port = 0;
`endif
      do_access($sformatf("arb%0d", i), exp_port,
                (exp_port == 1) ? 8'h20 : 8'h10,
                (exp_port == 1) ? 16'h2222 : 16'h1111);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step();
    step();

    // Back-to-back on port 1: req1 stays high after ack1
    bus.addr1 = 8'h55; bus.data1 = 16'hA5A5;
    bus.req1 = 1'b1;
    do_access("b2b1", 1, 8'h55, 16'hA5A5);
    gap = 1;
    step();
    while (bus.mem_write !== 1'b1 && gap < 10) begin
      gap++;
      step();
    end
    chk("b2b_gap", 32'(gap), 32'd2);
    do_access("b2b2", 1, 8'h55, 16'hA5A5);
    bus.req1 = 1'b0;
    step();
    step();

    // Shortest access (WAIT_CYCLES=1)
    bus1.req0 = 1'b1; bus1.addr0 = 8'hFE; bus1.data0 = 16'h0F0F;
    step();
    chk("w1_mw",   32'(bus1.mem_write), 32'd1);
    chk("w1_addr", 32'(bus1.mem_addr),  32'hFE);
    chk("w1_ack",  32'(bus1.ack0), 32'd0);
    step();
    chk("w1_mwoff", 32'(bus1.mem_write), 32'd0);
    chk("w1_ack0",  32'(bus1.ack0), 32'd1);
    chk("w1_ack1",  32'(bus1.ack1), 32'd0);
    bus1.req0 = 1'b0;
    step();
    chk("w1_ackclr", 32'(bus1.ack0), 32'd0);
    chk("w1_idle",   32'(bus1.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
